// File: rtl/mips_bus_pkg.sv
// mips_bus_pkg: definitions shared by the data-memory responder and the core's
// MEM-stage request logic.
//   WORD_BYTES - bytes per bus word
//   dm_state_t - responder FSM state encoding
//   dm_req_t   - one captured load/store request
//   be_legal() - byte-enable / address-alignment legality check
package mips_bus_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    DM_IDLE,
    DM_WAIT,
    DM_RESP
  } dm_state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } dm_req_t;

  // Legal enables: a full word on a word boundary, a half on a half
  // boundary, or a single byte whose lane matches the low address bits.
  function automatic logic be_legal(input logic [3:0] be, input logic [1:0] addr_lo);
    logic ok;
    case (be)
      4'b1111: ok = (addr_lo == 2'd0);
      4'b0011: ok = (addr_lo == 2'd0);
      4'b1100: ok = (addr_lo == 2'd2);
      4'b0001: ok = (addr_lo == 2'd0);
      4'b0010: ok = (addr_lo == 2'd1);
      4'b0100: ok = (addr_lo == 2'd2);
      4'b1000: ok = (addr_lo == 2'd3);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dm_ram.sv
// dm_ram: single-port synchronous RAM, DEPTH_WORDS x 32, per-byte write
// enables and a registered read port.
//   clk   - clock
//   en    - access strobe for this cycle
//   we    - byte write enables; all zero makes the access a read
//   addr  - word index
//   wdata - lane-aligned write data
//   rdata - read data, updated only by a read access and held otherwise
module dm_ram
  import mips_bus_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // NOTE: the array and its read register have no reset; clearing a RAM on
  // reset is not something the macro can do, and it keeps this a plain RAM.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      // Reads only update rdata, so the word stays put for a stalled response.
      if (we == 4'b0000) rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dm_responder.sv
// dm_responder: slave end of the core's data-memory request/response
// handshake. One transaction at a time, WAIT_CYCLES wait states, byte-enabled
// stores, full-word loads, and an error response for illegal accesses.
//   clk, reset            - clock; asynchronous active-low reset
//   req_valid / req_ready - request handshake (req_ready high only in IDLE)
//   req_we                - 1 = store, 0 = load
//   req_addr              - byte address
//   req_wdata             - lane-aligned store data
//   req_be                - byte enables
//   resp_valid/resp_ready - response handshake
//   resp_rdata            - aligned load word; 0 for stores and errors
//   resp_err              - illegal request, nothing was written
module dm_responder
  import mips_bus_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT = (WAIT_CYCLES > 1) ? CW'(WAIT_CYCLES - 1) : '0;

  dm_state_t    state;
  dm_req_t      req_q;
  logic [CW-1:0] cnt;
  logic         err_q;
  logic         rd_sel_q;

  dm_req_t      cur;
  logic [31:0]  offset;
  logic         in_range;
  logic         legal;
  logic         commit;
  logic [31:0]  ram_rdata;

  // In IDLE the live request is used so a zero-wait access can commit on the
  // accepting edge; afterwards the captured copy drives the checks and RAM.
  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    cur = req_q;
    if (state == DM_IDLE) begin
      cur.we    = req_we;
      cur.addr  = req_addr;
      cur.wdata = req_wdata;
      cur.be    = req_be;
    end
  end

  // Unsigned subtraction wraps, so addresses below BASE_ADDR land far out of
  // range and are rejected by the same compare.
  assign offset   = cur.addr - BASE_ADDR;
  assign in_range = (offset >> (AW + 2)) == 32'd0;
  assign legal    = in_range && be_legal(cur.be, cur.addr[1:0]);

  // The edge that enters RESP is the commit point.
  assign commit = ((state == DM_IDLE) && req_valid && (WAIT_CYCLES == 0)) ||
                  ((state == DM_WAIT) && (cnt == '0));

  dm_ram #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_ram (
    .clk   (clk),
    .en    (commit && legal),
    .we    (cur.we ? cur.be : 4'b0000),
    .addr  (offset[AW+1:2]),
    .wdata (cur.wdata),
    .rdata (ram_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= DM_IDLE;
      req_q    <= '0;
      cnt      <= '0;
      err_q    <= 1'b0;
      rd_sel_q <= 1'b0;
    end else begin
      case (state)
        DM_IDLE: begin
          if (req_valid) begin
            req_q <= cur;
            if (WAIT_CYCLES == 0) begin
              state    <= DM_RESP;
              err_q    <= !legal;
              rd_sel_q <= legal && !cur.we;
            end else begin
              state <= DM_WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        DM_WAIT: begin
          if (cnt == '0) begin
            state    <= DM_RESP;
            err_q    <= !legal;
            rd_sel_q <= legal && !cur.we;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DM_RESP: begin
          if (resp_ready) begin
            state    <= DM_IDLE;
            err_q    <= 1'b0;
            rd_sel_q <= 1'b0;
          end
        end
        default: state <= DM_IDLE;
      endcase
    end
  end

  assign req_ready  = (state == DM_IDLE);
  assign resp_valid = (state == DM_RESP);
  assign resp_err   = err_q;
  // The RAM read register holds the loaded word; rd_sel_q zeroes it for
  // stores, errors and whenever no response is pending.
  assign resp_rdata = rd_sel_q ? ram_rdata : 32'd0;

endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder: scoreboard bench for dm_responder. Three instances cover
// WAIT_CYCLES=2 (base 0), WAIT_CYCLES=0 (base 0x1000_0000) and WAIT_CYCLES=4.
// Expected responses are pushed when a request is driven and popped when the
// responder completes a response handshake.
module tb_dm_responder;

  typedef struct {
    int          d;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk;
  logic [2:0]  rst_n;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [2:0]  req_we;
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  logic [3:0]  req_be    [3];
  logic [2:0]  resp_valid;
  logic [2:0]  resp_ready;
  logic [31:0] resp_rdata [3];
  logic [2:0]  resp_err;

  int          w_of    [3] = '{2, 0, 4};
  logic [31:0] base_of [3] = '{32'h0000_0000, 32'h1000_0000, 32'h0000_0000};

  logic [31:0] model [3][1024];
  exp_t        sb [$];
  exp_t        mon_e;
  int          cyc;
  int          last_acc [3];
  int          first    [3];
  bit          seen     [3];
  int          n_checks;
  int          n_pass;

  dm_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(2)) u_dm0 (
    .clk(clk), .reset(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]),
    .resp_err(resp_err[0]));

  dm_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h1000_0000), .WAIT_CYCLES(0)) u_dm1 (
    .clk(clk), .reset(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]),
    .resp_err(resp_err[1]));

  dm_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(4)) u_dm2 (
    .clk(clk), .reset(rst_n[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_we(req_we[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_be(req_be[2]),
    .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]), .resp_rdata(resp_rdata[2]),
    .resp_err(resp_err[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  // Reference model: legality, range, byte-lane merge and expected response.
  task automatic expect_push(input int d, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] be);
    exp_t        e;
    logic [31:0] off;
    logic        ok;
    int          idx;
    off = addr - base_of[d];
    ok  = (off < 32'd4096) &&
          ((be == 4'hF && addr[1:0] == 2'd0) ||
           (be == 4'h3 && addr[1:0] == 2'd0) ||
           (be == 4'hC && addr[1:0] == 2'd2) ||
           (be == (4'b0001 << addr[1:0])));
    idx     = int'(off[11:2]);
    e.d     = d;
    e.err   = !ok;
    e.rdata = 32'd0;
    if (ok && we) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) model[d][idx][8*i +: 8] = wdata[8*i +: 8];
    end
    if (ok && !we) e.rdata = model[d][idx];
    sb.push_back(e);
  endtask

  task automatic drive(input int d, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
    req_we[d]    = we;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    req_be[d]    = be;
    req_valid[d] = 1'b1;
  endtask

  // Holds req_valid until an edge at which req_ready was high; returns at
  // that edge + 1 with the accept cycle.
  task automatic wait_accept(input int d, output int t0);
    int n;
    bit got;
    n   = 0;
    got = 1'b0;
    while (!got && n < 50) begin
      @(negedge clk);
      got = req_ready[d];
      @(posedge clk);
      #1;
      n++;
    end
    req_valid[d] = 1'b0;
    check("accepted", {31'd0, got}, 32'd1);
    t0 = cyc;
    last_acc[d] = cyc;
  endtask

  task automatic send(input int d, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be, output int t0);
    drive(d, we, addr, wdata, be);
    expect_push(d, we, addr, wdata, be);
    wait_accept(d, t0);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain", sb.size(), 32'd0);
  endtask

  task automatic chk_idle(input int d, input string pfx);
    check({pfx, "_req_ready"},  {31'd0, req_ready[d]},  32'd1);
    check({pfx, "_resp_valid"}, {31'd0, resp_valid[d]}, 32'd0);
    check({pfx, "_resp_err"},   {31'd0, resp_err[d]},   32'd0);
    check({pfx, "_resp_rdata"}, resp_rdata[d],          32'd0);
  endtask

  // Response monitor: pops one expectation per completed handshake.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (!rst_n[d]) begin
        seen[d] = 1'b0;
      end else begin
        if (resp_valid[d] && !seen[d]) begin
          seen[d]  = 1'b1;
          first[d] = cyc;
        end
        if (resp_valid[d] && resp_ready[d]) begin
          seen[d] = 1'b0;
          if (sb.size() == 0) begin
            check("spurious_resp", sb.size(), 32'd1);
          end else begin
            mon_e = sb.pop_front();
            check("resp_dut",   d, mon_e.d);
            check("resp_rdata", resp_rdata[d], mon_e.rdata);
            check("resp_err",   {31'd0, resp_err[d]}, {31'd0, mon_e.err});
            check("resp_latency", first[d], last_acc[d] + w_of[d]);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t, tp, c;
    n_checks   = 0;
    n_pass     = 0;
    cyc        = 0;
    rst_n      = 3'b000;
    req_valid  = 3'b000;
    req_we     = 3'b000;
    resp_ready = 3'b111;
    for (int d = 0; d < 3; d++) begin
      req_addr[d]  = '0;
      req_wdata[d] = '0;
      req_be[d]    = '0;
      last_acc[d]  = 0;
      first[d]     = 0;
      seen[d]      = 1'b0;
      for (int i = 0; i < 1024; i++) model[d][i] = '0;
    end
    // Simulation starts with zeroed RAM contents.
    for (int i = 0; i < 1024; i++) begin
      u_dm0.u_ram.mem[i] = '0;
      u_dm1.u_ram.mem[i] = '0;
      u_dm2.u_ram.mem[i] = '0;
    end

    #1;
    for (int d = 0; d < 3; d++) chk_idle(d, "rst");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 3'b111;
    @(posedge clk);
    #1;
    chk_idle(0, "post_rst");

    // Store then load, WAIT_CYCLES=2: one transaction per 4 cycles.
    send(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, tp);
    send(0, 1'b0, 32'h10, 32'h0, 4'hF, t);
    check("gap_w2", t - tp, 32'd4);

    // Byte and half lanes merge into one word.
    send(0, 1'b1, 32'h21, 32'h0000_5A00, 4'b0010, t);
    send(0, 1'b1, 32'h22, 32'h1234_0000, 4'b1100, t);
    send(0, 1'b0, 32'h20, 32'h0, 4'hF, t);

    // Illegal accesses: misaligned half, out of range, empty and wrong-lane enables.
    send(0, 1'b1, 32'h23, 32'hFFFF_0000, 4'b1100, t);
    send(0, 1'b0, 32'h20, 32'h0, 4'hF, t);
    send(0, 1'b0, 32'h1000, 32'h0, 4'hF, t);
    send(0, 1'b1, 32'h1000, 32'hCAFE_F00D, 4'hF, t);
    send(0, 1'b0, 32'h20, 32'h0, 4'b0000, t);
    send(0, 1'b0, 32'h21, 32'h0, 4'b0001, t);
    send(0, 1'b0, 32'h21, 32'h0, 4'b0010, t);
    send(0, 1'b0, 32'hFFC, 32'h0, 4'hF, t);
    wait_drain();

    // Backpressure: response held for 5 cycles while a store waits.
    resp_ready[0] = 1'b0;
    send(0, 1'b0, 32'h10, 32'h0, 4'hF, t);
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_resp_valid", {31'd0, resp_valid[0]}, 32'd1);
      check("bp_resp_rdata", resp_rdata[0], 32'hDEAD_BEEF);
      check("bp_resp_err",   {31'd0, resp_err[0]}, 32'd0);
      check("bp_req_ready",  {31'd0, req_ready[0]}, 32'd0);
      @(posedge clk);
      #1;
      if (i == 1) begin
        drive(0, 1'b1, 32'h14, 32'h0BAD_F00D, 4'hF);
        expect_push(0, 1'b1, 32'h14, 32'h0BAD_F00D, 4'hF);
      end
    end
    c = cyc;
    resp_ready[0] = 1'b1;
    wait_accept(0, t);
    check("bp_accept_cycle", t, c + 2);
    send(0, 1'b0, 32'h14, 32'h0, 4'hF, t);
    wait_drain();

    // Zero wait states, non-zero base: one transaction per 2 cycles.
    send(1, 1'b1, 32'h1000_0000, 32'h1111_1111, 4'hF, tp);
    send(1, 1'b1, 32'h1000_0004, 32'h2222_2222, 4'hF, t);
    check("gap_w0_s1", t - tp, 32'd2);
    tp = t;
    send(1, 1'b1, 32'h1000_0008, 32'h3333_3333, 4'hF, t);
    check("gap_w0_s2", t - tp, 32'd2);
    tp = t;
    send(1, 1'b0, 32'h1000_0000, 32'h0, 4'hF, t);
    check("gap_w0_l0", t - tp, 32'd2);
    tp = t;
    send(1, 1'b0, 32'h1000_0004, 32'h0, 4'hF, t);
    check("gap_w0_l1", t - tp, 32'd2);
    tp = t;
    send(1, 1'b0, 32'h1000_0008, 32'h0, 4'hF, t);
    check("gap_w0_l2", t - tp, 32'd2);
    send(1, 1'b0, 32'h0FFF_FFFC, 32'h0, 4'hF, t);
    send(1, 1'b1, 32'h1000_0FFC, 32'h7777_8888, 4'b0011, t);
    send(1, 1'b0, 32'h1000_0FFC, 32'h0, 4'hF, t);
    wait_drain();

    // Reset during WAIT drops the store.
    drive(2, 1'b1, 32'h40, 32'hAABB_CCDD, 4'hF);
    wait_accept(2, t);
    repeat (2) @(posedge clk);
    #1;
    rst_n[2] = 1'b0;
    #1;
    chk_idle(2, "rst_wait");
    @(posedge clk);
    #1;
    rst_n[2] = 1'b1;
    @(posedge clk);
    #1;
    send(2, 1'b0, 32'h40, 32'h0, 4'hF, t);
    wait_drain();

    // Reset during RESP drops the response but the store already landed.
    resp_ready[2] = 1'b0;
    drive(2, 1'b1, 32'h48, 32'h5566_7788, 4'hF);
    wait_accept(2, t);
    model[2][18] = 32'h5566_7788;
    repeat (4) @(posedge clk);
    #1;
    check("rst_resp_valid_before", {31'd0, resp_valid[2]}, 32'd1);
    rst_n[2] = 1'b0;
    #1;
    chk_idle(2, "rst_resp");
    @(posedge clk);
    #1;
    rst_n[2]      = 1'b1;
    resp_ready[2] = 1'b1;
    @(posedge clk);
    #1;
    send(2, 1'b0, 32'h48, 32'h0, 4'hF, t);
    send(2, 1'b1, 32'h44, 32'h0102_0304, 4'b1000, t);
    send(2, 1'b0, 32'h44, 32'h0, 4'hF, t);
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dm_responder.md
# dm_responder

Data-memory responder for the pipelined MIPS core: the slave end of the core's load/store request/response handshake. Accepts one request at a time, applies a parameterised number of wait states, commits byte-enabled writes or returns aligned read words, and flags illegal accesses. It replaces the core's zero-latency internal data memory, so the pipeline's stall logic is exercised against a real variable-latency responder.

## Interface
- `DEPTH_WORDS`, 1024: RAM size in 32-bit words (4 KiB); power of two.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0.
- `WAIT_CYCLES`, 2: wait states inserted per transaction; 0 is legal.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept; high only in IDLE.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, already lane-aligned.
- `req_be`  in  4  byte enables; bit i selects bits 8i+7:8i.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  core accepts the response.
- `resp_rdata`  out  32  full aligned word for loads; 0 for stores and errors.
- `resp_err`  out  1  request was illegal; no side effects.

## Operation
- FSM states: IDLE, WAIT, RESP.
  - IDLE: `req_ready`=1. On `req_valid`: latch we/addr/wdata/be, go to WAIT (counter loaded with WAIT_CYCLES-1), or go directly to RESP when WAIT_CYCLES=0.
  - WAIT: decrement the counter; at 0, go to RESP.
  - RESP: `resp_valid`=1; hold all resp outputs stable until `resp_ready`, then go to IDLE.
- Commit point is the edge that enters RESP. At that edge:
  - a legal store writes the enabled lanes;
  - a legal load registers the word into `resp_rdata`.
- Legal be/addr pairs:
  - 4'b1111 with addr[1:0]=0;
  - 4'b0011 / 4'b1100 with addr[1:0]=0 / 2;
  - a one-hot be whose set bit index equals addr[1:0].
- Any other be value, including 4'b0000, is an error.
- Range check: addr − BASE_ADDR (unsigned, 32-bit wrap) must be < DEPTH_WORDS×4; otherwise error.
- Word index: (addr − BASE_ADDR)[log2(DEPTH_WORDS)+1:2].
- Error response: `resp_err`=1, `resp_rdata`=0, RAM untouched.
- Loads ignore `req_be` for data; the full word is returned, and the core does lane select and extension. `req_be` is still checked for legality.
- The RAM is not cleared by reset. Simulation initialises it to zero.

## Timing
- Reset (asynchronous assert, synchronous release): state=IDLE, `req_ready`=1, `resp_valid`=0, `resp_err`=0, `resp_rdata`=0, counter=0.
- Latency: accept at edge t0 → `resp_valid` high in the cycle after edge t0+WAIT_CYCLES. The store commits at that same edge; with WAIT_CYCLES=0 it commits at t0.
- Throughput: at most one transaction per WAIT_CYCLES+2 cycles with `resp_ready` tied high. `req_ready` drops in the cycle after acceptance.
- `req_ready` and `resp_valid` are registered-state decodes; there is no combinational path from `req_valid` or `resp_ready` to either.
- `req_valid` seen while not IDLE is ignored. The core must hold the request until it is accepted.
- Reset asserted mid-WAIT: the transaction is dropped and its store is not committed. Reset asserted mid-RESP: the response is dropped, but an already-committed store persists.
- A new request cannot overlap a pending response. There is exactly one outstanding transaction at any time.

## Structure
- Package `mips_bus_pkg` holds:
  - the state enum `dm_state_t`;
  - the function `be_legal(be, addr_lo)`;
  - the constant `WORD_BYTES`=4.
- The package is shared with the core's MEM-stage request logic.
- Sub-module `dm_ram`: single-port synchronous RAM with per-byte write enables and registered read, DEPTH_WORDS×32.
- The FSM, wait counter and legality/range checks live in `dm_responder`.

## Test plan
- **Store then load:** WAIT_CYCLES=2; store 32'hDEAD_BEEF at 0x10, be=1111; then load 0x10. Each `resp_valid` rises 3 cycles after `req_valid`; the load returns 32'hDEAD_BEEF with `resp_err`=0.
- **Byte and half lanes:** over word 0x20=32'h0, store byte 0x5A at 0x21 (be=0010), then half 0x1234 at 0x22 (be=1100). A load of 0x20 returns 32'h1234_5A00.
- **Errors:**
  - Half store at 0x23 (be=1100) → `resp_err`=1, RAM unchanged.
  - Load at BASE+4096 → `resp_err`=1, `resp_rdata`=0.
- **Backpressure:** hold `resp_ready`=0 for 5 cycles. `resp_valid`, `resp_rdata` and `resp_err` stay stable and `req_ready` stays 0. A pending `req_valid` is accepted in the cycle after the response handshake.
- **Zero wait, back-to-back:** WAIT_CYCLES=0 with `resp_ready` high. Three stores then three loads complete one per 2 cycles; read data matches.
- **Reset mid-WAIT:** WAIT_CYCLES=4; pulse reset low during WAIT of a store to 0x40. All outputs return to reset values immediately; a subsequent load of 0x40 returns its prior value (0).
